tag_dispatch: RTL and testbench

- Consumer end of the tag/rdy/ack arbitration handshake. Sits between a tag tree root and an upstream packet stream.
- On the first beat of each packet, it claims the ready leaf the tree offers by pulsing ack and latching the tag.
- It then steers every beat of that packet to the selected core only and signals packet end to that core.
- Packets arriving when no core is ready are dropped and counted.

---
 rtl/tag_dispatch_pkg.sv | 21 ++
 rtl/tag_onehot_decode.sv | 21 ++
 rtl/tag_dispatch.sv | 118 +++++++++++
 tb/tb_tag_dispatch.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/tag_dispatch_pkg.sv
// Shared definitions for the tag-tree arbitration blocks: dispatcher state encoding
// and the width helper used to size tag buses from a core count.
package tag_dispatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DROP   = 2'd2
    } state_e;

    // Minimum index width for v leaves, never less than one bit.
    function automatic int clog2(input int v);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/tag_onehot_decode.sv
// Tag index to one-hot core select, with a flag for indices beyond the core count.
// Latency: combinational.
// Backpressure: none, pure decode.
module tag_onehot_decode #(
    parameter int N      = 4,
    parameter int TAG_SZ = 2
) (
    input  logic [TAG_SZ-1:0] tag_i,
    output logic [N-1:0]      onehot_o,
    output logic              oor_o
);

    always_comb begin
        onehot_o = '0;
        oor_o    = (int'(tag_i) >= N);
        for (int i = 0; i < N; i++) begin
            onehot_o[i] = (int'(tag_i) == i);
        end
    end

endmodule

// File: rtl/tag_dispatch.sv
// Claims a ready core from the tag tree on each packet start and steers the packet to it.
// Latency: 1 cycle from input beat to out_data/out_wr_en/out_done; ack is combinational.
// Backpressure: none; every beat is accepted, packets with no usable core are dropped and counted.
module tag_dispatch
    import tag_dispatch_pkg::*;
#(
    parameter int N          = 4,
    parameter int TAG_SZ     = clog2(N),
    parameter int DATA_WIDTH = 32,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [TAG_SZ-1:0]     tag,
    input  logic                  rdy,
    output logic                  ack,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    input  logic                  in_last,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [N-1:0]          out_wr_en,
    output logic [N-1:0]          out_done,
    output logic                  busy,
    output logic [CNT_W-1:0]      drop_cnt
);

    state_e                  state_q, state_d;
    logic [N-1:0]            sel_q, sel_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic [N-1:0]            wr_q, wr_d;
    logic [N-1:0]            done_q, done_d;
    logic                    busy_q;
    logic [CNT_W-1:0]        drop_cnt_q;
    logic                    drop_inc;
    logic [N-1:0]            tag_onehot;
    logic                    tag_oor;

    tag_onehot_decode #(
        .N      (N),
        .TAG_SZ (TAG_SZ)
    ) u_decode (
        .tag_i    (tag),
        .onehot_o (tag_onehot),
        .oor_o    (tag_oor)
    );

    // Grant is only offered from IDLE, so one packet can never claim two leaves.
    assign ack = rst & (state_q == ST_IDLE) & in_valid & rdy;

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        data_d   = data_q;
        wr_d     = '0;
        done_d   = '0;
        drop_inc = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    if (rdy && !tag_oor) begin
                        sel_d  = tag_onehot;
                        data_d = in_data;
                        wr_d   = tag_onehot;
                        if (in_last) done_d  = tag_onehot;
                        else         state_d = ST_STREAM;
                    end else begin
                        drop_inc = 1'b1;
                        if (!in_last) state_d = ST_DROP;
                    end
                end
            end
            ST_STREAM: begin
                if (in_valid) begin
                    data_d = in_data;
                    wr_d   = sel_q;
                    if (in_last) begin
                        done_d  = sel_q;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_DROP: begin
                if (in_valid && in_last) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // The latched tag is held as its one-hot select so streaming beats need no re-decode.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            sel_q      <= '0;
            data_q     <= '0;
            wr_q       <= '0;
            done_q     <= '0;
            busy_q     <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            data_q  <= data_d;
            wr_q    <= wr_d;
            done_q  <= done_d;
            busy_q  <= (state_d != ST_IDLE);
            if (drop_inc && (drop_cnt_q != {CNT_W{1'b1}})) begin
                drop_cnt_q <= drop_cnt_q + CNT_W'(1);
            end
        end
    end

    assign out_data  = data_q;
    assign out_wr_en = wr_q;
    assign out_done  = done_q;
    assign busy      = busy_q;
    assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_tag_dispatch.sv
// Drives two dispatchers from one stimulus stream: a 4-core/16-bit-counter build and a
// 3-core/2-bit-counter build that sees out-of-range tags and counter saturation.
module tb_tag_dispatch;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  tag;
    logic        rdy;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_last;

    logic        ack0, ack1;
    logic [31:0] od0, od1;
    logic [3:0]  wr0, dn0;
    logic [2:0]  wr1, dn1;
    logic        busy0, busy1;
    logic [15:0] cnt0;
    logic [1:0]  cnt1;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    tag_dispatch #(.N(4), .TAG_SZ(2), .DATA_WIDTH(32), .CNT_W(16)) dut0 (
        .clk(clk), .rst(rst), .tag(tag), .rdy(rdy), .ack(ack0),
        .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
        .out_data(od0), .out_wr_en(wr0), .out_done(dn0), .busy(busy0), .drop_cnt(cnt0)
    );

    tag_dispatch #(.N(3), .TAG_SZ(2), .DATA_WIDTH(32), .CNT_W(2)) dut1 (
        .clk(clk), .rst(rst), .tag(tag), .rdy(rdy), .ack(ack1),
        .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
        .out_data(od1), .out_wr_en(wr1), .out_done(dn1), .busy(busy1), .drop_cnt(cnt1)
    );

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Packet-level reference: per build, whether a packet is open and which core (or none) owns it.
    int          m_inpkt [2];
    int          m_dest  [2];
    int          m_drops [2];
    int          m_wr    [2];
    int          m_dn    [2];
    logic [31:0] m_data  [2];

    function automatic int n_of(input int k);
        return (k == 0) ? 4 : 3;
    endfunction

    function automatic int cnt_max(input int k);
        return (k == 0) ? 65535 : 3;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_inpkt[k] = 0; m_dest[k] = 0; m_drops[k] = 0;
            m_wr[k] = 0; m_dn[k] = 0; m_data[k] = '0;
        end
    endtask

    task automatic check_outputs();
        int c0, c1;
        c0 = (m_drops[0] > cnt_max(0)) ? cnt_max(0) : m_drops[0];
        c1 = (m_drops[1] > cnt_max(1)) ? cnt_max(1) : m_drops[1];
        chk("data0", od0, m_data[0]);
        chk("wr0", wr0, m_wr[0]);
        chk("done0", dn0, m_dn[0]);
        chk("busy0", busy0, m_inpkt[0]);
        chk("drop0", cnt0, c0);
        chk("data1", od1, m_data[1]);
        chk("wr1", wr1, m_wr[1]);
        chk("done1", dn1, m_dn[1]);
        chk("busy1", busy1, m_inpkt[1]);
        chk("drop1", cnt1, c1);
    endtask

    task automatic beat(input bit v, input bit l, input logic [31:0] d, input bit r, input int t);
        @(negedge clk);
        in_valid = v; in_last = l; in_data = d; rdy = r; tag = 2'(t);
        #1;
        chk("ack0", ack0, (m_inpkt[0] == 0) && v && r);
        chk("ack1", ack1, (m_inpkt[1] == 0) && v && r);
        for (int k = 0; k < 2; k++) begin
            m_wr[k] = 0;
            m_dn[k] = 0;
            if (v) begin
                if (m_inpkt[k] == 0) begin
                    if (r && t < n_of(k)) m_dest[k] = t;
                    else begin
                        m_dest[k] = -1;
                        m_drops[k]++;
                    end
                end
                if (m_dest[k] >= 0) begin
                    m_wr[k]   = 1 << m_dest[k];
                    m_data[k] = d;
                    if (l) m_dn[k] = 1 << m_dest[k];
                end
                m_inpkt[k] = l ? 0 : 1;
            end
        end
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    int sat_exp [5] = '{1, 2, 3, 3, 3};

    initial begin
        rst = 1'b0; tag = '0; rdy = 1'b0; in_data = '0; in_valid = 1'b0; in_last = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outputs();
        chk("ack0_rst", ack0, 0);
        @(negedge clk) rst = 1'b1;

        // 3-beat packet to core 2
        beat(1, 0, 32'hA, 1, 2);
        beat(1, 0, 32'hB, 1, 2);
        beat(1, 1, 32'hC, 1, 2);
        beat(0, 0, 32'h0, 0, 0);

        // no ready core: dropped, then delivered to core 0
        beat(1, 0, 32'h11, 0, 0);
        beat(1, 1, 32'h12, 0, 0);
        beat(1, 0, 32'hD, 1, 0);
        beat(1, 1, 32'hE, 1, 0);

        // single-beat packet to core 3 (out of range for the 3-core build)
        beat(1, 1, 32'hF, 1, 3);
        beat(0, 0, 32'h0, 1, 1);

        // back-to-back packets with tag changes mid-packet
        beat(1, 0, 32'h21, 1, 1);
        beat(1, 1, 32'h22, 1, 2);
        beat(1, 0, 32'h23, 1, 3);
        beat(1, 1, 32'h24, 1, 0);
        beat(0, 1, 32'h25, 1, 1);

        // asynchronous reset in the middle of a packet to core 1
        beat(1, 0, 32'h31, 1, 1);
        beat(1, 0, 32'h32, 1, 1);
        #1;
        rst = 1'b0; in_valid = 1'b1; rdy = 1'b1; tag = 2'd0;
        #1;
        chk("rst_wr0", wr0, 0);
        chk("rst_busy0", busy0, 0);
        chk("rst_data0", od0, 0);
        chk("rst_drop0", cnt0, 0);
        chk("rst_ack0", ack0, 0);
        chk("rst_ack1", ack1, 0);
        in_valid = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk) rst = 1'b1;
        beat(1, 1, 32'h40, 1, 0);

        // drop counter saturation on the 2-bit build
        for (int i = 0; i < 5; i++) begin
            beat(1, 1, 32'h50 + i, 0, 1);
            chk("sat1", cnt1, sat_exp[i]);
        end

        for (int i = 0; i < 400; i++) begin
            beat(($urandom % 4) != 0, ($urandom % 3) == 0, $urandom,
                 ($urandom % 4) != 0, int'($urandom % 4));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
